tia_audio_divider: RTL

Multi-channel, parametrised audio frequency divider for the TIA audio path. Each channel holds a programmable divisor and divides a shared enable tick by 2·(divisor+1), producing a square-wave clock and a one-cycle reload pulse for the downstream poly/noise generators. Divisors are written through a simple register-write port, with optional phase restart. The block sits between the TIA timing chain (audio tick source) and the per-channel waveform generators.

---
 rtl/tia_audio_divider_if.sv | 26 ++
 rtl/tia_audio_divider.sv | 71 +++++++
 2 files changed

// File: rtl/tia_audio_divider_if.sv
// Control/status bundle for the TIA audio divider: tick, run mask, divisor write port
// and the per-channel divided clock and reload outputs.
interface tia_audio_divider_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 5,
  parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic                tick_en;
  logic [CHANNELS-1:0] ch_en;
  logic                wr_en;
  logic [CW-1:0]       wr_chan;
  logic [WIDTH-1:0]    wr_data;
  logic                wr_restart;
  logic [CHANNELS-1:0] d_clk;
  logic [CHANNELS-1:0] reload;

  modport master (
    output tick_en, ch_en, wr_en, wr_chan, wr_data, wr_restart,
    input  d_clk, reload
  );

  modport slave (
    input  tick_en, ch_en, wr_en, wr_chan, wr_data, wr_restart,
    output d_clk, reload
  );
endinterface

// File: rtl/tia_audio_divider.sv
// Multi-channel audio divider: each channel divides the shared tick by 2*(div+1),
// producing a registered square wave and a one-cycle reload pulse.
module tia_audio_divider #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 5,
  parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  tia_audio_divider_if.slave bus
);

  logic [WIDTH-1:0]    div_q  [CHANNELS];
  logic [WIDTH-1:0]    div_n  [CHANNELS];
  logic [WIDTH-1:0]    cnt_q  [CHANNELS];
  logic [WIDTH-1:0]    cnt_n  [CHANNELS];
  logic [CHANNELS-1:0] d_clk_q, d_clk_n;
  logic [CHANNELS-1:0] reload_q, reload_n;
  logic [CW-1:0]       sel;

  assign sel = bus.wr_chan;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      div_n[c]    = div_q[c];
      cnt_n[c]    = cnt_q[c];
      d_clk_n[c]  = d_clk_q[c];
      reload_n[c] = 1'b0;

      // Out-of-range selects never match any channel, so they fall through as no-ops.
      if (bus.wr_en && (int'(sel) == c) && bus.wr_restart) begin
        cnt_n[c]   = bus.wr_data;
        d_clk_n[c] = 1'b0;
      end else if (bus.tick_en && bus.ch_en[c]) begin
        if (cnt_q[c] == '0) begin
          cnt_n[c]    = div_q[c];
          d_clk_n[c]  = ~d_clk_q[c];
          reload_n[c] = 1'b1;
        end else begin
          cnt_n[c] = cnt_q[c] - WIDTH'(1);
        end
      end

      if (bus.wr_en && (int'(sel) == c)) begin
        div_n[c] = bus.wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        div_q[c] <= '0;
        cnt_q[c] <= '0;
      end
      d_clk_q  <= '0;
      reload_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        div_q[c] <= div_n[c];
        cnt_q[c] <= cnt_n[c];
      end
      d_clk_q  <= d_clk_n;
      reload_q <= reload_n;
    end
  end

  assign bus.d_clk  = d_clk_q;
  assign bus.reload = reload_q;

endmodule
